triumph_mem_stage: RTL and testbench

TRIUMPH_MEM_STAGE -- requirements
Module: triumph_mem_stage

---
 rtl/triumph_mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_triumph_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/triumph_mem_stage.sv
// Memory stage: accepts EX results, issues aligned dcache load/store requests,
// formats load data and produces a single registered writeback per transaction.
module triumph_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [1:0]  ex_memop_i,
  input  logic [1:0]  ex_size_i,
  input  logic        ex_unsigned_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_rd_we_i,
  output logic        dcache_req_o,
  input  logic        dcache_gnt_i,
  output logic [31:0] dcache_addr_o,
  output logic        dcache_we_o,
  output logic [3:0]  dcache_be_o,
  output logic [31:0] dcache_wdata_o,
  input  logic        dcache_rvalid_i,
  input  logic [31:0] dcache_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_we_o,
  output logic [31:0] wb_data_o,
  output logic        err_misalign_o,
  output logic        err_timeout_o
);

  // state  | meaning
  // IDLE   | ready for a new EX transfer
  // REQ    | dcache request asserted, waiting for grant
  // WAIT   | load granted, waiting for rvalid or timeout
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;

  logic        xfer, in_load, in_store, in_mem, in_misalign;
  logic        timeout_hit;
  logic [31:0] rshift, load_data;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    xfer        = ex_valid_i && ex_ready_o;
    in_load     = (ex_memop_i == 2'b01);
    in_store    = (ex_memop_i == 2'b10);
    in_mem      = in_load || in_store;
    in_misalign = in_mem && ((ex_size_i == 2'b11) ||
                             (ex_size_i == 2'b01 && ex_result_i[0]) ||
                             (ex_size_i == 2'b10 && ex_result_i[1:0] != 2'b00));
    timeout_hit = (state_q == S_WAIT) && !dcache_rvalid_i && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      rd_we_q    <= rd_we_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (xfer && in_mem && !in_misalign) state_d = S_REQ;
      S_REQ:  if (dcache_gnt_i) state_d = store_q ? S_IDLE : S_WAIT;
      S_WAIT: if (dcache_rvalid_i || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    if (xfer) begin
      addr_d  = ex_result_i;
      wdata_d = ex_wdata_i;
      size_d  = ex_size_i;
      uns_d   = ex_unsigned_i;
      store_d = in_store;
      rd_d    = ex_rd_i;
      rd_we_d = ex_rd_we_i;
    end
    cnt_d = '0;
    if (state_q == S_WAIT && !dcache_rvalid_i) cnt_d = cnt_q + 8'd1;
  end

  // Load alignment and extension; rdata is word-aligned from the cache
  always_comb begin
    rshift = dcache_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = {{16{~uns_q & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (xfer && (!in_mem || in_misalign)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = ex_rd_i;
          wb_data_d  = ex_result_i;
          wb_we_d    = !in_mem && ex_rd_we_i && (ex_rd_i != 5'd0);
          err_mis_d  = in_misalign;
        end
      end
      S_REQ: begin
        if (dcache_gnt_i && store_q) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = addr_q;
          wb_we_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (dcache_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
          wb_we_d    = rd_we_q && (rd_q != 5'd0);
        end else if (timeout_hit) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = addr_q;
          wb_we_d    = 1'b0;
          err_to_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_ready_o     = rstn_i && (state_q == S_IDLE);
    dcache_req_o   = (state_q == S_REQ);
    dcache_addr_o  = dcache_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
    dcache_we_o    = dcache_req_o && store_q;
    dcache_be_o    = dcache_req_o ? st_be : 4'd0;
    dcache_wdata_o = (dcache_req_o && store_q) ? st_wdata : 32'd0;
    wb_valid_o     = wb_valid_q;
    wb_rd_o        = wb_rd_q;
    wb_we_o        = wb_we_q;
    wb_data_o      = wb_data_q;
    err_misalign_o = err_mis_q;
    err_timeout_o  = err_to_q;
  end

endmodule

// File: tb/tb_triumph_mem_stage.sv
// Directed self-checking bench for triumph_mem_stage.
module tb_triumph_mem_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_result_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic [1:0]  ex_memop_i = '0;
  logic [1:0]  ex_size_i = '0;
  logic        ex_unsigned_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_rd_we_i = 1'b0;
  logic        dcache_req_o;
  logic        dcache_gnt_i = 1'b0;
  logic [31:0] dcache_addr_o;
  logic        dcache_we_o;
  logic [3:0]  dcache_be_o;
  logic [31:0] dcache_wdata_o;
  logic        dcache_rvalid_i = 1'b0;
  logic [31:0] dcache_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic [31:0] wb_data_o;
  logic        err_misalign_o;
  logic        err_timeout_o;

  int vecs = 0;
  int errs = 0;

  triumph_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_result_i(ex_result_i), .ex_wdata_i(ex_wdata_i),
    .ex_memop_i(ex_memop_i), .ex_size_i(ex_size_i), .ex_unsigned_i(ex_unsigned_i),
    .ex_rd_i(ex_rd_i), .ex_rd_we_i(ex_rd_we_i),
    .dcache_req_o(dcache_req_o), .dcache_gnt_i(dcache_gnt_i),
    .dcache_addr_o(dcache_addr_o), .dcache_we_o(dcache_we_o),
    .dcache_be_o(dcache_be_o), .dcache_wdata_o(dcache_wdata_o),
    .dcache_rvalid_i(dcache_rvalid_i), .dcache_rdata_i(dcache_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
    .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one EX transfer; returns one cycle after the transfer edge
  task automatic issue(input logic [1:0] memop, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic we);
    ex_memop_i = memop; ex_size_i = size; ex_unsigned_i = uns;
    ex_result_i = addr; ex_wdata_i = wdata; ex_rd_i = rd; ex_rd_we_i = we;
    ex_valid_i = 1'b1;
    tick();
    ex_valid_i = 1'b0;
    ex_memop_i = 2'b00;
  endtask

  task automatic test_reset();
    #2;
    vecs++; if (ex_ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready got %b exp 0", ex_ready_o); end
    vecs++; if (wb_valid_o !== 1'b0 || dcache_req_o !== 1'b0 || err_timeout_o !== 1'b0 || err_misalign_o !== 1'b0)
      begin errs++; $display("FAIL rst_outputs got wbv=%b req=%b errs=%b%b exp 0", wb_valid_o, dcache_req_o, err_timeout_o, err_misalign_o); end
    tick();
    rstn_i = 1'b1;
    #1;
    vecs++; if (ex_ready_o !== 1'b1) begin errs++; $display("FAIL rst_release_ready got %b exp 1", ex_ready_o); end
  endtask

  task automatic test_nonmem();
    issue(2'b00, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
    vecs++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_data_o !== 32'h1234 || wb_we_o !== 1'b1)
      begin errs++; $display("FAIL nonmem got v=%b rd=%0d d=%h we=%b exp 1/5/00001234/1", wb_valid_o, wb_rd_o, wb_data_o, wb_we_o); end
    tick();
    vecs++; if (wb_valid_o !== 1'b0 || wb_data_o !== 32'h1234) begin errs++; $display("FAIL nonmem_pulse got v=%b d=%h exp 0/00001234", wb_valid_o, wb_data_o); end
    issue(2'b11, 2'b11, 1'b0, 32'h77, 32'h0, 5'd0, 1'b1);
    vecs++; if (wb_valid_o !== 1'b1 || wb_we_o !== 1'b0 || wb_data_o !== 32'h77 || err_misalign_o !== 1'b0 || dcache_req_o !== 1'b0)
      begin errs++; $display("FAIL nonmem_rd0 got v=%b we=%b d=%h mis=%b req=%b exp 1/0/00000077/0/0", wb_valid_o, wb_we_o, wb_data_o, err_misalign_o, dcache_req_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    ex_memop_i = 2'b00; ex_rd_we_i = 1'b1; ex_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_result_i = 32'hA000 + i; ex_rd_i = 5'(i + 1);
      tick();
      vecs++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hA000 + i || wb_rd_o !== 5'(i + 1) || ex_ready_o !== 1'b1)
        begin errs++; $display("FAIL b2b_%0d got v=%b d=%h rd=%0d rdy=%b", i, wb_valid_o, wb_data_o, wb_rd_o, ex_ready_o); end
    end
    ex_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_store_byte();
    issue(2'b10, 2'b00, 1'b0, 32'h103, 32'h000000AB, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      vecs++; if (dcache_req_o !== 1'b1 || dcache_addr_o !== 32'h100 || dcache_be_o !== 4'b1000 ||
                  dcache_wdata_o !== 32'hABABABAB || dcache_we_o !== 1'b1 || ex_ready_o !== 1'b0 || wb_valid_o !== 1'b0)
        begin errs++; $display("FAIL st_byte_hold_%0d got req=%b a=%h be=%b wd=%h we=%b rdy=%b wbv=%b", i,
                               dcache_req_o, dcache_addr_o, dcache_be_o, dcache_wdata_o, dcache_we_o, ex_ready_o, wb_valid_o); end
      if (i == 2) dcache_gnt_i = 1'b1;
      tick();
    end
    dcache_gnt_i = 1'b0;
    vecs++; if (wb_valid_o !== 1'b1 || wb_we_o !== 1'b0 || dcache_req_o !== 1'b0 || ex_ready_o !== 1'b1)
      begin errs++; $display("FAIL st_byte_done got v=%b we=%b req=%b rdy=%b exp 1/0/0/1", wb_valid_o, wb_we_o, dcache_req_o, ex_ready_o); end
    tick();
  endtask

  task automatic test_store_half_word();
    issue(2'b10, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd2, 1'b1);
    vecs++; if (dcache_be_o !== 4'b1100 || dcache_wdata_o !== 32'hABCDABCD || dcache_addr_o !== 32'h200)
      begin errs++; $display("FAIL st_half got be=%b wd=%h a=%h exp 1100/abcdabcd/00000200", dcache_be_o, dcache_wdata_o, dcache_addr_o); end
    dcache_gnt_i = 1'b1; tick(); dcache_gnt_i = 1'b0;
    tick();
    issue(2'b10, 2'b10, 1'b0, 32'h208, 32'hCAFEF00D, 5'd2, 1'b1);
    vecs++; if (dcache_be_o !== 4'b1111 || dcache_wdata_o !== 32'hCAFEF00D || dcache_addr_o !== 32'h208)
      begin errs++; $display("FAIL st_word got be=%b wd=%h a=%h exp 1111/cafef00d/00000208", dcache_be_o, dcache_wdata_o, dcache_addr_o); end
    dcache_gnt_i = 1'b1; tick(); dcache_gnt_i = 1'b0;
    tick();
  endtask

  // Load granted at once; a stray rvalid during REQ must be ignored; rvalid 2 cycles after gnt
  task automatic load_case(input string nm, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] exp);
    issue(2'b01, size, uns, addr, 32'h0, 5'd7, 1'b1);
    vecs++; if (dcache_req_o !== 1'b1 || dcache_we_o !== 1'b0 || dcache_addr_o !== {addr[31:2], 2'b00})
      begin errs++; $display("FAIL %s_req got req=%b we=%b a=%h", nm, dcache_req_o, dcache_we_o, dcache_addr_o); end
    dcache_gnt_i = 1'b1; dcache_rvalid_i = 1'b1; dcache_rdata_i = 32'hDEADBEEF;
    tick();
    dcache_gnt_i = 1'b0; dcache_rvalid_i = 1'b0;
    tick();
    vecs++; if (wb_valid_o !== 1'b0 || dcache_req_o !== 1'b0 || ex_ready_o !== 1'b0)
      begin errs++; $display("FAIL %s_wait got v=%b req=%b rdy=%b exp 0/0/0", nm, wb_valid_o, dcache_req_o, ex_ready_o); end
    dcache_rvalid_i = 1'b1; dcache_rdata_i = rdata;
    tick();
    dcache_rvalid_i = 1'b0;
    vecs++; if (wb_valid_o !== 1'b1 || wb_data_o !== exp || wb_we_o !== 1'b1 || wb_rd_o !== 5'd7 || err_timeout_o !== 1'b0)
      begin errs++; $display("FAIL %s got v=%b d=%h we=%b rd=%0d to=%b exp d=%h", nm, wb_valid_o, wb_data_o, wb_we_o, wb_rd_o, err_timeout_o, exp); end
    tick();
  endtask

  task automatic test_loads();
    load_case("ld_half_s", 2'b01, 1'b0, 32'h202, 32'h80010000, 32'hFFFF8001);
    load_case("ld_half_u", 2'b01, 1'b1, 32'h202, 32'h80010000, 32'h00008001);
    load_case("ld_byte_s", 2'b00, 1'b0, 32'h101, 32'h0000F100, 32'hFFFFFFF1);
    load_case("ld_word",   2'b10, 1'b0, 32'h104, 32'h11223344, 32'h11223344);
  endtask

  task automatic test_misalign();
    issue(2'b01, 2'b10, 1'b0, 32'h301, 32'h0, 5'd3, 1'b1);
    vecs++; if (err_misalign_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_we_o !== 1'b0 || dcache_req_o !== 1'b0 || ex_ready_o !== 1'b1)
      begin errs++; $display("FAIL misalign got mis=%b v=%b we=%b req=%b rdy=%b exp 1/1/0/0/1", err_misalign_o, wb_valid_o, wb_we_o, dcache_req_o, ex_ready_o); end
    tick();
    vecs++; if (err_misalign_o !== 1'b0 || dcache_req_o !== 1'b0) begin errs++; $display("FAIL misalign_pulse got mis=%b req=%b exp 0/0", err_misalign_o, dcache_req_o); end
    issue(2'b10, 2'b01, 1'b0, 32'h405, 32'h0, 5'd3, 1'b0);
    vecs++; if (err_misalign_o !== 1'b1 || dcache_req_o !== 1'b0) begin errs++; $display("FAIL misalign_half got mis=%b req=%b exp 1/0", err_misalign_o, dcache_req_o); end
    tick();
  endtask

  task automatic test_timeout();
    issue(2'b01, 2'b10, 1'b0, 32'h400, 32'h0, 5'd4, 1'b1);
    dcache_gnt_i = 1'b1; tick(); dcache_gnt_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      vecs++; if (wb_valid_o !== 1'b0 || err_timeout_o !== 1'b0) begin errs++; $display("FAIL to_early_%0d got v=%b to=%b exp 0/0", k, wb_valid_o, err_timeout_o); end
      tick();
    end
    vecs++; if (err_timeout_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_we_o !== 1'b0 || ex_ready_o !== 1'b1)
      begin errs++; $display("FAIL timeout got to=%b v=%b we=%b rdy=%b exp 1/1/0/1", err_timeout_o, wb_valid_o, wb_we_o, ex_ready_o); end
    dcache_rvalid_i = 1'b1; dcache_rdata_i = 32'h55;
    tick();
    dcache_rvalid_i = 1'b0;
    vecs++; if (wb_valid_o !== 1'b0 || err_timeout_o !== 1'b0) begin errs++; $display("FAIL late_rvalid got v=%b to=%b exp 0/0", wb_valid_o, err_timeout_o); end
    issue(2'b01, 2'b10, 1'b0, 32'h400, 32'h0, 5'd4, 1'b1);
    dcache_gnt_i = 1'b1; tick(); dcache_gnt_i = 1'b0;
    for (int k = 1; k < 16; k++) tick();
    dcache_rvalid_i = 1'b1; dcache_rdata_i = 32'h0BADCAFE;
    tick();
    dcache_rvalid_i = 1'b0;
    vecs++; if (err_timeout_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_data_o !== 32'h0BADCAFE || wb_we_o !== 1'b1)
      begin errs++; $display("FAIL rvalid_at_limit got to=%b v=%b d=%h we=%b exp 0/1/0badcafe/1", err_timeout_o, wb_valid_o, wb_data_o, wb_we_o); end
    tick();
  endtask

  task automatic test_reset_inflight();
    issue(2'b10, 2'b10, 1'b0, 32'h500, 32'h1, 5'd6, 1'b1);
    vecs++; if (dcache_req_o !== 1'b1) begin errs++; $display("FAIL rst_req_pre got %b exp 1", dcache_req_o); end
    #2 rstn_i = 1'b0; #1;
    vecs++; if (dcache_req_o !== 1'b0 || dcache_be_o !== 4'd0 || ex_ready_o !== 1'b0)
      begin errs++; $display("FAIL rst_in_req got req=%b be=%b rdy=%b exp 0/0/0", dcache_req_o, dcache_be_o, ex_ready_o); end
    tick(); rstn_i = 1'b1; tick();
    issue(2'b01, 2'b10, 1'b0, 32'h600, 32'h0, 5'd6, 1'b1);
    dcache_gnt_i = 1'b1; tick(); dcache_gnt_i = 1'b0;
    tick();
    #2 rstn_i = 1'b0; #1;
    vecs++; if (dcache_req_o !== 1'b0 || wb_valid_o !== 1'b0 || ex_ready_o !== 1'b0)
      begin errs++; $display("FAIL rst_in_wait got req=%b v=%b rdy=%b exp 0/0/0", dcache_req_o, wb_valid_o, ex_ready_o); end
    tick(); rstn_i = 1'b1;
    dcache_rvalid_i = 1'b1; dcache_rdata_i = 32'h99;
    tick();
    dcache_rvalid_i = 1'b0;
    vecs++; if (wb_valid_o !== 1'b0 || err_timeout_o !== 1'b0 || ex_ready_o !== 1'b1)
      begin errs++; $display("FAIL rst_no_pulse got v=%b to=%b rdy=%b exp 0/0/1", wb_valid_o, err_timeout_o, ex_ready_o); end
    issue(2'b00, 2'b00, 1'b0, 32'h4242, 32'h0, 5'd8, 1'b1);
    vecs++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h4242 || wb_rd_o !== 5'd8 || wb_we_o !== 1'b1)
      begin errs++; $display("FAIL rst_after_op got v=%b d=%h rd=%0d we=%b exp 1/00004242/8/1", wb_valid_o, wb_data_o, wb_rd_o, wb_we_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_back_to_back();
    test_store_byte();
    test_store_half_word();
    test_loads();
    test_misalign();
    test_timeout();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
